// File: rtl/ekf_stage_sequencer_if.sv
// Handshake and result bus between the EKF stage sequencer and its requester/compute units.
interface ekf_stage_sequencer_if #(
  parameter int RSA_DW  = 16,
  parameter int ROW_LEN = 10,
  parameter int RES_CH  = 6
);
  logic [2:0]               stage_val;
  logic [2:0]               stage_rdy;
  logic [ROW_LEN-1:0]       landmark_num;
  logic [ROW_LEN-1:0]       l_k;
  logic                     init_predict;
  logic                     init_newlm;
  logic                     init_update;
  logic                     done_predict;
  logic                     done_newlm;
  logic                     done_update;
  logic [RES_CH*RSA_DW-1:0] result_flat;
  logic [RES_CH*RSA_DW-1:0] res_q;
  logic                     res_vld;
  logic [2:0]               res_stage;
  logic [ROW_LEN-1:0]       lk_q;
  logic                     busy;
  logic                     err_timeout;
  logic                     err_illegal;
  logic                     err_clr;

  modport master (
    output stage_val, landmark_num, l_k, done_predict, done_newlm, done_update,
           result_flat, err_clr,
    input  stage_rdy, init_predict, init_newlm, init_update, res_q, res_vld,
           res_stage, lk_q, busy, err_timeout, err_illegal
  );

  modport slave (
    input  stage_val, landmark_num, l_k, done_predict, done_newlm, done_update,
           result_flat, err_clr,
    output stage_rdy, init_predict, init_newlm, init_update, res_q, res_vld,
           res_stage, lk_q, busy, err_timeout, err_illegal
  );
endinterface

// File: rtl/ekf_stage_sequencer.sv
// EKF-SLAM stage controller: one-hot request -> init pulse -> wait for done (with watchdog) -> capture results.
module ekf_stage_sequencer #(
  parameter int RSA_DW   = 16,
  parameter int ROW_LEN  = 10,
  parameter int RES_CH   = 6,
  parameter int TO_CW    = 16,
  parameter int TO_LIMIT = 1000
) (
  input logic                  clk,
  input logic                  sys_rst,
  ekf_stage_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, INIT, WAIT, CAPT} state_t;

  localparam logic [TO_CW-1:0] TO_LAST = TO_CW'(TO_LIMIT - 1);

  state_t             state;
  logic [2:0]         stage;
  logic [TO_CW-1:0]   cnt;
  logic               onehot, accept, done_act, illegal_set, to_set;

  always_comb begin
    bus.stage_rdy = 3'b000;
    if (state == IDLE)
      bus.stage_rdy = {(bus.landmark_num != '0) && (bus.l_k < bus.landmark_num), 2'b11};
  end

  assign onehot      = bus.stage_val inside {3'b001, 3'b010, 3'b100};
  assign accept      = (state == IDLE) && onehot && |(bus.stage_val & bus.stage_rdy);
  assign illegal_set = (state == IDLE) && (bus.stage_val != 3'b000) && !accept;
  // Only the unit we started may complete the transaction.
  assign done_act    = |(stage & {bus.done_update, bus.done_newlm, bus.done_predict});
  assign to_set      = (state == WAIT) && !done_act && (cnt == TO_LAST);

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state            <= IDLE;
      stage            <= 3'b000;
      cnt              <= '0;
      bus.init_predict <= 1'b0;
      bus.init_newlm   <= 1'b0;
      bus.init_update  <= 1'b0;
      bus.res_q        <= '0;
      bus.res_vld      <= 1'b0;
      bus.res_stage    <= 3'b000;
      bus.lk_q         <= '0;
      bus.busy         <= 1'b0;
    end else begin
      bus.init_predict <= 1'b0;
      bus.init_newlm   <= 1'b0;
      bus.init_update  <= 1'b0;
      bus.res_vld      <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          stage            <= bus.stage_val;
          bus.lk_q         <= bus.l_k;
          bus.init_predict <= bus.stage_val[0];
          bus.init_newlm   <= bus.stage_val[1];
          bus.init_update  <= bus.stage_val[2];
          bus.busy         <= 1'b1;
          state            <= INIT;
        end
        INIT: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (done_act) begin
            bus.res_q     <= bus.result_flat;
            bus.res_stage <= stage;
            bus.res_vld   <= 1'b1;
            state         <= CAPT;
          end else if (cnt == TO_LAST) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + TO_CW'(1);
          end
        end
        CAPT: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Sticky errors: a new set on the same edge as err_clr keeps the flag high.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      bus.err_timeout <= 1'b0;
      bus.err_illegal <= 1'b0;
    end else begin
      if (to_set)           bus.err_timeout <= 1'b1;
      else if (bus.err_clr) bus.err_timeout <= 1'b0;
      if (illegal_set)      bus.err_illegal <= 1'b1;
      else if (bus.err_clr) bus.err_illegal <= 1'b0;
    end
  end
endmodule
